// File: rtl/tl_rx_vc_ordering_buffer_if.sv
// Handshake bundle for the RX virtual-channel ordering buffer: arrival-order
// writes and head pops in, head type, occupancy and sticky errors out.
interface tl_rx_vc_ordering_buffer_if #(
    parameter int P_HDR_FIFO_DEPTH   = 8,
    parameter int NP_HDR_FIFO_DEPTH  = 4,
    parameter int CPL_HDR_FIFO_DEPTH = 4
);
    localparam int DEPTH = P_HDR_FIFO_DEPTH + NP_HDR_FIFO_DEPTH + CPL_HDR_FIFO_DEPTH;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int PW    = $clog2(P_HDR_FIFO_DEPTH) + 1;
    localparam int NW    = $clog2(NP_HDR_FIFO_DEPTH) + 1;
    localparam int CPW   = $clog2(CPL_HDR_FIFO_DEPTH) + 1;

    logic           i_w_inc;
    logic [1:0]     i_w_buffer_type;
    logic           i_r_inc;
    logic           i_err_clr;
    logic [1:0]     o_r_buffer_type;
    logic           o_empty_flag;
    logic           o_full_flag;
    logic [CW-1:0]  o_count;
    logic [PW-1:0]  o_p_count;
    logic [NW-1:0]  o_np_count;
    logic [CPW-1:0] o_cpl_count;
    logic           o_ovf_err;
    logic           o_udf_err;

    modport master (
        output i_w_inc, i_w_buffer_type, i_r_inc, i_err_clr,
        input  o_r_buffer_type, o_empty_flag, o_full_flag, o_count,
               o_p_count, o_np_count, o_cpl_count, o_ovf_err, o_udf_err
    );

    modport slave (
        input  i_w_inc, i_w_buffer_type, i_r_inc, i_err_clr,
        output o_r_buffer_type, o_empty_flag, o_full_flag, o_count,
               o_p_count, o_np_count, o_cpl_count, o_ovf_err, o_udf_err
    );
endinterface

// File: rtl/tl_rx_vc_ordering_buffer.sv
// Arrival-order record of received TLP types (P/NP/CPL) with per-type
// occupancy limits, so headers can be released strictly in arrival order.
module tl_rx_vc_ordering_buffer #(
    parameter int P_HDR_FIFO_DEPTH   = 8,
    parameter int NP_HDR_FIFO_DEPTH  = 4,
    parameter int CPL_HDR_FIFO_DEPTH = 4
) (
    input logic                       i_clk,
    input logic                       i_n_rst,
    tl_rx_vc_ordering_buffer_if.slave bus
);
    localparam int DEPTH = P_HDR_FIFO_DEPTH + NP_HDR_FIFO_DEPTH + CPL_HDR_FIFO_DEPTH;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int PW    = $clog2(P_HDR_FIFO_DEPTH) + 1;
    localparam int NW    = $clog2(NP_HDR_FIFO_DEPTH) + 1;
    localparam int CPW   = $clog2(CPL_HDR_FIFO_DEPTH) + 1;

    localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [PW-1:0]  P_MAX     = PW'(P_HDR_FIFO_DEPTH);
    localparam logic [NW-1:0]  NP_MAX    = NW'(NP_HDR_FIFO_DEPTH);
    localparam logic [CPW-1:0] CPL_MAX   = CPW'(CPL_HDR_FIFO_DEPTH);

    typedef enum logic [1:0] {
        TLP_P    = 2'd0,
        TLP_NP   = 2'd1,
        TLP_CPL  = 2'd2,
        TLP_RSVD = 2'd3
    } tlp_type_e;

    logic [1:0]     mem_q [DEPTH];
    logic [1:0]     mem_d [DEPTH];
    logic [CW-1:0]  wptr_q, wptr_d;
    logic [CW-1:0]  rptr_q, rptr_d;
    logic [PW-1:0]  p_cnt_q, p_cnt_d;
    logic [NW-1:0]  np_cnt_q, np_cnt_d;
    logic [CPW-1:0] cpl_cnt_q, cpl_cnt_d;
    logic           ovf_q, ovf_d;
    logic           udf_q, udf_d;

    logic       empty;
    logic       full;
    logic [1:0] head_type;
    logic       type_room;
    logic       wr_ok;
    logic       rd_ok;

    // Non-power-of-two depth: wrap the address explicitly and flip the lap bit.
    function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
        if (p[AW-1:0] == LAST_ADDR) begin
            return {~p[CW-1], {AW{1'b0}}};
        end
        return p + CW'(1);
    endfunction

    assign empty     = (wptr_q == rptr_q);
    assign full      = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[CW-1] != rptr_q[CW-1]);
    assign head_type = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        type_room = 1'b0;
        case (bus.i_w_buffer_type)
            TLP_P:   type_room = (p_cnt_q < P_MAX);
            TLP_NP:  type_room = (np_cnt_q < NP_MAX);
            TLP_CPL: type_room = (cpl_cnt_q < CPL_MAX);
            default: type_room = 1'b0;
        endcase
    end

    assign wr_ok = bus.i_w_inc && !full && type_room;
    assign rd_ok = bus.i_r_inc && !empty;

    always_comb begin
        mem_d     = mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        p_cnt_d   = p_cnt_q;
        np_cnt_d  = np_cnt_q;
        cpl_cnt_d = cpl_cnt_q;

        if (wr_ok) begin
            mem_d[wptr_q[AW-1:0]] = bus.i_w_buffer_type;
            wptr_d                = ptr_inc(wptr_q);
            case (bus.i_w_buffer_type)
                TLP_P:   p_cnt_d   = p_cnt_d + PW'(1);
                TLP_NP:  np_cnt_d  = np_cnt_d + NW'(1);
                TLP_CPL: cpl_cnt_d = cpl_cnt_d + CPW'(1);
                default: ;
            endcase
        end

        if (rd_ok) begin
            rptr_d = ptr_inc(rptr_q);
            case (head_type)
                TLP_P:   p_cnt_d   = p_cnt_d - PW'(1);
                TLP_NP:  np_cnt_d  = np_cnt_d - NW'(1);
                TLP_CPL: cpl_cnt_d = cpl_cnt_d - CPW'(1);
                default: ;
            endcase
        end

        // A fresh error event outranks a same-cycle clear.
        ovf_d = ovf_q;
        if (bus.i_err_clr) ovf_d = 1'b0;
        if (bus.i_w_inc && !wr_ok) ovf_d = 1'b1;

        udf_d = udf_q;
        if (bus.i_err_clr) udf_d = 1'b0;
        if (bus.i_r_inc && empty) udf_d = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            mem_q     <= '{default: '0};
            wptr_q    <= '0;
            rptr_q    <= '0;
            p_cnt_q   <= '0;
            np_cnt_q  <= '0;
            cpl_cnt_q <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            p_cnt_q   <= p_cnt_d;
            np_cnt_q  <= np_cnt_d;
            cpl_cnt_q <= cpl_cnt_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    assign bus.o_r_buffer_type = empty ? 2'd0 : head_type;
    assign bus.o_empty_flag    = empty;
    assign bus.o_full_flag     = full;
    assign bus.o_count         = CW'(p_cnt_q) + CW'(np_cnt_q) + CW'(cpl_cnt_q);
    assign bus.o_p_count       = p_cnt_q;
    assign bus.o_np_count      = np_cnt_q;
    assign bus.o_cpl_count     = cpl_cnt_q;
    assign bus.o_ovf_err       = ovf_q;
    assign bus.o_udf_err       = udf_q;
endmodule

// File: tb/tb_tl_rx_vc_ordering_buffer.sv
// Ordering-buffer bench: directed scenarios plus random traffic, all checked
// against a queue-based model of arrival order and per-type limits.
module tb_tl_rx_vc_ordering_buffer;
    localparam int P_D   = 4;
    localparam int NP_D  = 2;
    localparam int CPL_D = 2;
    localparam int DEPTH = P_D + NP_D + CPL_D;

    logic i_clk;
    logic i_n_rst;

    tl_rx_vc_ordering_buffer_if #(
        .P_HDR_FIFO_DEPTH(P_D),
        .NP_HDR_FIFO_DEPTH(NP_D),
        .CPL_HDR_FIFO_DEPTH(CPL_D)
    ) bus ();

    tl_rx_vc_ordering_buffer #(
        .P_HDR_FIFO_DEPTH(P_D),
        .NP_HDR_FIFO_DEPTH(NP_D),
        .CPL_HDR_FIFO_DEPTH(CPL_D)
    ) dut (
        .i_clk   (i_clk),
        .i_n_rst (i_n_rst),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_fail = 0;

    int unsigned mdl_q[$];
    bit          mdl_ovf;
    bit          mdl_udf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned type_cnt(input int unsigned t);
        int unsigned c = 0;
        foreach (mdl_q[i]) if (mdl_q[i] == t) c++;
        return c;
    endfunction

    function automatic int unsigned type_cap(input int unsigned t);
        case (t)
            0:       return P_D;
            1:       return NP_D;
            2:       return CPL_D;
            default: return 0;
        endcase
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".empty"}, 32'(bus.o_empty_flag), 32'(mdl_q.size() == 0));
        chk({tag, ".full"},  32'(bus.o_full_flag),  32'(mdl_q.size() == DEPTH));
        chk({tag, ".count"}, 32'(bus.o_count),      32'(mdl_q.size()));
        chk({tag, ".p"},     32'(bus.o_p_count),    type_cnt(0));
        chk({tag, ".np"},    32'(bus.o_np_count),   type_cnt(1));
        chk({tag, ".cpl"},   32'(bus.o_cpl_count),  type_cnt(2));
        chk({tag, ".head"},  32'(bus.o_r_buffer_type), (mdl_q.size() == 0) ? 32'd0 : mdl_q[0]);
        chk({tag, ".ovf"},   32'(bus.o_ovf_err),    32'(mdl_ovf));
        chk({tag, ".udf"},   32'(bus.o_udf_err),    32'(mdl_udf));
    endtask

    task automatic model_reset();
        mdl_q.delete();
        mdl_ovf = 1'b0;
        mdl_udf = 1'b0;
    endtask

    // One clock: drive, let the edge happen, advance the model from pre-edge state, check.
    task automatic step(input string tag, input bit w, input int unsigned t, input bit r, input bit clr);
        bit w_ok;
        bit r_ok;
        bus.i_w_inc         = w;
        bus.i_w_buffer_type = 2'(t);
        bus.i_r_inc         = r;
        bus.i_err_clr       = clr;
        w_ok = w && (mdl_q.size() < DEPTH) && (t != 3) && (type_cnt(t) < type_cap(t));
        r_ok = r && (mdl_q.size() != 0);
        @(posedge i_clk);
        if (clr) begin
            mdl_ovf = 1'b0;
            mdl_udf = 1'b0;
        end
        if (w && !w_ok) mdl_ovf = 1'b1;
        if (r && !r_ok) mdl_udf = 1'b1;
        if (r_ok) void'(mdl_q.pop_front());
        if (w_ok) mdl_q.push_back(t);
        #1;
        check_all(tag);
        bus.i_w_inc   = 1'b0;
        bus.i_r_inc   = 1'b0;
        bus.i_err_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_n_rst = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(negedge i_clk);
        i_n_rst = 1'b1;
    endtask

    initial begin
        int unsigned wprob;
        int unsigned rprob;
        int unsigned t;
        i_n_rst             = 1'b0;
        bus.i_w_inc         = 1'b0;
        bus.i_w_buffer_type = 2'd0;
        bus.i_r_inc         = 1'b0;
        bus.i_err_clr       = 1'b0;
        model_reset();
        #12;
        check_all("por");
        @(negedge i_clk);
        i_n_rst = 1'b1;

        // In-order pop across types
        step("ord_w", 1, 0, 0, 0);
        step("ord_w", 1, 1, 0, 0);
        step("ord_w", 1, 2, 0, 0);
        step("ord_w", 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("ord_r", 0, 0, 1, 0);

        // Fill to full, then overflow
        for (int i = 0; i < 4; i++) step("fill_p", 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) step("fill_np", 1, 1, 0, 0);
        for (int i = 0; i < 2; i++) step("fill_cpl", 1, 2, 0, 0);
        step("ovf_full", 1, 0, 0, 0);

        // Full with read+write in the same cycle, alternating types, wrapping pointers
        for (int i = 0; i < 20; i++) step("rw_wrap", 1, i % 3, 1, 0);
        while (mdl_q.size() != 0) step("drain", 0, 0, 1, 0);
        step("clr", 0, 0, 0, 1);

        // Per-type limit with plenty of total space
        for (int i = 0; i < 3; i++) step("np_lim", 1, 1, 0, 0);
        step("np_clr", 0, 0, 0, 1);
        for (int i = 0; i < 2; i++) step("np_drain", 0, 0, 1, 0);

        // Underflow plus reserved-type write, then error-vs-clear priority
        step("udf_rsvd", 1, 3, 1, 0);
        step("err_win", 1, 3, 1, 1);
        step("clr2", 0, 0, 0, 1);
        step("w_empty_r", 1, 2, 1, 0);
        step("r_one", 0, 0, 1, 0);

        // Asynchronous reset mid-stream with 5 entries stored
        for (int i = 0; i < 5; i++) step("pre_rst", 1, i % 3, 0, 0);
        #2;
        i_n_rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge i_clk);
        i_n_rst = 1'b1;
        step("post_rst", 1, 1, 0, 0);

        // Random traffic with shifting fill/drain bias
        for (int blk = 0; blk < 8; blk++) begin
            wprob = $urandom_range(20, 90);
            rprob = $urandom_range(20, 90);
            for (int i = 0; i < 50; i++) begin
                t = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
                step("rand", $urandom_range(0, 99) < wprob, t,
                     $urandom_range(0, 99) < rprob, $urandom_range(0, 9) == 0);
            end
            if (blk == 4) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
